// File: rtl/rf_dump_streamer_pkg.sv
// Shared definitions for the register-file dump streamer: FSM encoding,
// word/byte geometry and the RF address that maps to PC.
package rf_dump_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          DATA_W_DEFAULT = 32;
  localparam int          BYTES_PER_WORD = DATA_W_DEFAULT / 8;
  localparam logic [3:0]  PC_ADDR        = 4'hf;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/rf_dump_streamer_byte_serializer.sv
// Loads one Data_W word and emits it LSB byte first over valid/ready,
// flagging the final byte so the parent can sequence words.
module rf_byte_serializer
  import rf_dump_streamer_pkg::*;
#(
  parameter int Data_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [Data_W-1:0] word_i,
  input  logic              out_ready_i,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  output logic              last_byte_o,
  output logic              fire_o
);

  localparam int NB = bytes_per_word(Data_W);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [Data_W-1:0] shift_q;
  logic [IW-1:0]     idx_q;
  logic              valid_q;

  assign out_data_o  = shift_q[7:0];
  assign out_valid_o = valid_q;
  assign last_byte_o = (idx_q == IW'(NB - 1));
  assign fire_o      = valid_q & out_ready_i;

  // Load wins over a concurrent transfer: the parent reloads exactly on
  // the edge that consumes the previous word's last byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire_o) begin
      shift_q <= shift_q >> 8;
      idx_q   <= idx_q + 1'b1;
      if (last_byte_o) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_dump_streamer.sv
// Debug dump engine: walks a register range through one RF read port,
// streams each word as bytes, then appends a running 32-bit checksum.
module rf_dump_streamer
  import rf_dump_streamer_pkg::*;
#(
  parameter int Addr_W = 16,
  parameter int Data_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(Addr_W)-1:0]  first_addr,
  input  logic [$clog2(Addr_W)-1:0]  last_addr,
  output logic [$clog2(Addr_W)-1:0]  rf_read_addr,
  input  logic [Data_W-1:0]          rf_read_data,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(Addr_W);

  state_e            state_q;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     last_q;
  logic [Data_W-1:0] csum_q;
  logic              busy_q;
  logic              done_q;

  logic              ser_load;
  logic [Data_W-1:0] ser_word;
  logic              ser_last;
  logic              ser_fire;
  logic              word_end;

  assign word_end = ser_fire & ser_last;

  // csum_q already includes the final word when SEND hands over to CSUM.
  always_comb begin
    ser_load = 1'b0;
    ser_word = csum_q;
    if (state_q == ST_FETCH) begin
      ser_load = 1'b1;
      ser_word = rf_read_data;
    end else if (state_q == ST_SEND && word_end && addr_q == last_q) begin
      ser_load = 1'b1;
    end
  end

  rf_byte_serializer #(.Data_W(Data_W)) u_ser (
    .clock       (clock),
    .reset       (reset),
    .load_i      (ser_load),
    .word_i      (ser_word),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .last_byte_o (ser_last),
    .fire_o      (ser_fire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= first_addr;
            last_q  <= last_addr;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          csum_q  <= csum_q + rf_read_data;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (word_end) begin
            if (addr_q == last_q) begin
              state_q <= ST_CSUM;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (word_end) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rf_read_addr = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Scoreboard bench for rf_dump_streamer: expected bytes are queued from a
// register-file model at start and popped as the stream transfers.
module tb_rf_dump_streamer;
  import rf_dump_streamer_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [16];
  logic [7:0]  exp_q [$];
  int          errors = 0;
  int          checks = 0;

  assign rf_read_data = rf[rf_read_addr];

  rf_dump_streamer #(.Addr_W(16), .Data_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .first_addr   (first_addr),
    .last_addr    (last_addr),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic init_rf();
    for (int k = 0; k < 16; k++) rf[k] = 32'h11110000 + 32'(k);
    rf[PC_ADDR] = 32'hCAFE0000;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1 on valid cycles;
  // 2: ready high plus a second start with range f2..l2 while busy.
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                          input logic [3:0] f2, input logic [3:0] l2,
                          output int nbytes, output int ndone,
                          output int done_cyc, output int first_valid_cyc);
    int          n, cyc, vc;
    logic [31:0] sum, w;
    logic [3:0]  a;
    logic        prev_stall;
    logic [7:0]  prev_data, e;
    logic        pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    exp_q.delete();
    n = int'(4'(l - f)) + 1;
    sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = f + 4'(i);
      w = rf[a];
      sum = sum + w;
      for (int b = 0; b < BYTES_PER_WORD; b++) exp_q.push_back(w[8*b +: 8]);
    end
    for (int b = 0; b < BYTES_PER_WORD; b++) exp_q.push_back(sum[8*b +: 8]);
    nbytes = 0; ndone = 0; done_cyc = -1; first_valid_cyc = -1;
    vc = 0; prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clock);
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !(ndone > 0 && cyc > done_cyc + 3)) begin
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fetch_cycle: busy=%b out_valid=%b, required busy=1 out_valid=0", busy, out_valid);
        end
      end
      if (mode == 2 && cyc == 3) begin
        start = 1'b1; first_addr = f2; last_addr = l2;
      end else begin
        start = 1'b0;
      end
      if (mode == 1) begin
        out_ready = out_valid ? pat[vc % 4] : 1'b1;
        if (out_valid) vc++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        nbytes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h, required no further byte", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL byte_%0d: got %h, required %h", nbytes - 1, out_data, e);
          end
        end
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_cycle: out_valid=%b busy=%b, required 0 and 1", out_valid, busy);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    checks++;
    if (ndone == 0) begin
      errors++;
      $display("FAIL dump_timeout: no done within %0d cycles, required one done pulse", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_bytes: %0d expected bytes never sent, required 0", exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; first_addr = 4'h0; last_addr = 4'h0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_valid, busy, done, rf_read_addr, out_data} !== 15'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b addr=%h data=%h, required all 0",
               out_valid, busy, done, rf_read_addr, out_data);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_two_regs();
    int nb, nd, dc, fv;
    run_dump(4'd2, 4'd3, 0, 4'd0, 4'd0, nb, nd, dc, fv);
    checks++;
    if (nb != 12) begin errors++; $display("FAIL two_regs_count: got %0d bytes, required 12", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL two_regs_done: got %0d pulses, required 1", nd); end
    checks++;
    if (fv != 2) begin errors++; $display("FAIL first_valid_latency: cycle %0d, required 2", fv); end
    checks++;
    if (dc != 15) begin errors++; $display("FAIL two_regs_done_cycle: cycle %0d, required 15", dc); end
  endtask

  task automatic test_wrap();
    int nb, nd, dc, fv;
    run_dump(4'd14, 4'd1, 0, 4'd0, 4'd0, nb, nd, dc, fv);
    checks++;
    if (nb != 20) begin errors++; $display("FAIL wrap_count: got %0d bytes, required 20", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL wrap_done: got %0d pulses, required 1", nd); end
  endtask

  task automatic test_stall();
    int nb, nd, dc, fv;
    run_dump(4'd4, 4'd5, 1, 4'd0, 4'd0, nb, nd, dc, fv);
    checks++;
    if (nb != 12) begin errors++; $display("FAIL stall_count: got %0d bytes, required 12", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL stall_done: got %0d pulses, required 1", nd); end
  endtask

  task automatic test_back_to_back();
    int nb, nd, dc, fv;
    run_dump(4'd2, 4'd3, 2, 4'd9, 4'd12, nb, nd, dc, fv);
    checks++;
    if (nb != 12) begin errors++; $display("FAIL busy_start_count: got %0d bytes, required 12", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL busy_start_done: got %0d pulses, required 1", nd); end
  endtask

  task automatic test_single();
    int nb, nd, dc, fv;
    rf[7] = 32'hFFFFFFFF;
    run_dump(4'd7, 4'd7, 0, 4'd0, 4'd0, nb, nd, dc, fv);
    checks++;
    if (nb != 8) begin errors++; $display("FAIL single_count: got %0d bytes, required 8", nb); end
    checks++;
    if (dc != 10) begin errors++; $display("FAIL single_done_cycle: cycle %0d, required 10", dc); end
    init_rf();
  endtask

  task automatic test_reset_mid();
    int nb, nd, dc, fv, seen;
    @(negedge clock);
    first_addr = 4'd2; last_addr = 4'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, rf_read_addr} !== 7'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b addr=%h, required all 0",
               out_valid, busy, done, rf_read_addr);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_no_done: %0d done/busy cycles, required 0", seen); end
    run_dump(4'd0, 4'd0, 0, 4'd0, 4'd0, nb, nd, dc, fv);
    checks++;
    if (nb != 8 || nd != 1) begin
      errors++;
      $display("FAIL post_reset_dump: %0d bytes %0d done, required 8 and 1", nb, nd);
    end
  endtask

  initial begin
    init_rf();
    test_reset();
    test_two_regs();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_single();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
